// File: rtl/xy_route_unit.sv
// ---------------------------------------------------------------------------
// xy_route_unit
//
// Purpose: packet-aware route computation for one router input port of a 2D
// mesh. The direction is computed once from the head flit (XY or YX order
// selected by ROUTE_MODE), locked until the tail, and every forwarded flit
// passes through a one-deep registered output stage. Packets addressed
// outside the mesh are swallowed and flagged on err_o.
//
// Optional build macro: XY_ROUTE_STATS_EN adds pkt_cnt_o / drop_cnt_o.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   data_i     input flit, [FLIT_DATA_W+1:FLIT_DATA_W] = type
//              (01 head, 00 body, 10 tail, 11 single)
//   valid_i    input flit valid
//   ready_o    input flit accepted when valid_i && ready_o
//   data_o     registered output flit
//   valid_o    output flit valid
//   ready_i    downstream ready
//   out_sel_o  locked direction: 0 RESOURCE, 1 WEST, 2 EAST, 3 NORTH, 4 SOUTH
//   busy_o     packet in progress (ROUTE or DROP)
//   err_o      one-cycle pulse per discarded flit or packet
//   pkt_cnt_o  (XY_ROUTE_STATS_EN) forwarded tail/single count, wraps
//   drop_cnt_o (XY_ROUTE_STATS_EN) err_o pulse count, wraps
//
// FLIT_DATA_W must be >= PACKET_ADDR_X_W + PACKET_ADDR_Y_W.
// ---------------------------------------------------------------------------
module xy_route_unit #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PACKET_ADDR_X_W = 4,
  parameter int PACKET_ADDR_Y_W = 4,
  parameter int OUTPUT_N_W      = 3,
  parameter int FLIT_DATA_W     = 8,
  parameter int MESH_X          = 4,
  parameter int MESH_Y          = 4,
  parameter int ROUTE_MODE      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [FLIT_DATA_W+1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [FLIT_DATA_W+1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [OUTPUT_N_W-1:0]  out_sel_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef XY_ROUTE_STATS_EN
  ,
  output logic [15:0]            pkt_cnt_o,
  output logic [15:0]            drop_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam logic [OUTPUT_N_W-1:0] DIR_RESOURCE = OUTPUT_N_W'(0);
  localparam logic [OUTPUT_N_W-1:0] DIR_WEST     = OUTPUT_N_W'(1);
  localparam logic [OUTPUT_N_W-1:0] DIR_EAST     = OUTPUT_N_W'(2);
  localparam logic [OUTPUT_N_W-1:0] DIR_NORTH    = OUTPUT_N_W'(3);
  localparam logic [OUTPUT_N_W-1:0] DIR_SOUTH    = OUTPUT_N_W'(4);

  // Coordinates and mesh bounds widened to 32 bits so every compare is unsigned
  // and independent of the address field widths.
  localparam logic [31:0] C_X      = X_CORD;
  localparam logic [31:0] C_Y      = Y_CORD;
  localparam logic [31:0] C_MESH_X = MESH_X;
  localparam logic [31:0] C_MESH_Y = MESH_Y;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [FLIT_DATA_W+1:0]   r_data;
  logic                     r_valid;
  logic [OUTPUT_N_W-1:0]    r_sel;
  logic                     r_err;

  logic [1:0]               w_type;
  logic [31:0]              w_x;
  logic [31:0]              w_y;
  logic                     w_isStart;
  logic                     w_inRange;
  logic                     w_accept;
  logic                     w_fwd;
  logic                     w_err;
  logic [OUTPUT_N_W-1:0]    w_dir;
  logic [OUTPUT_N_W-1:0]    w_dirX;
  logic [OUTPUT_N_W-1:0]    w_dirY;

  assign w_type    = data_i[FLIT_DATA_W+1:FLIT_DATA_W];
  assign w_x       = 32'(data_i[PACKET_ADDR_X_W-1:0]);
  assign w_y       = 32'(data_i[PACKET_ADDR_X_W +: PACKET_ADDR_Y_W]);
  // Head and single both start a packet; they share the low type bit.
  assign w_isStart = (w_type == FLIT_HEAD) || (w_type == FLIT_SINGLE);
  assign w_inRange = (w_x < C_MESH_X) && (w_y < C_MESH_Y);
  assign w_accept  = valid_i && ready_o;

  // Per-dimension candidate directions, then dimension order picks which
  // differing axis wins. Both equal means the flit is for the local port.
  always_comb begin
    w_dirX = (w_x > C_X) ? DIR_EAST : DIR_WEST;
    w_dirY = (w_y > C_Y) ? DIR_NORTH : DIR_SOUTH;
    w_dir  = DIR_RESOURCE;
    if (ROUTE_MODE == 0) begin
      if (w_x != C_X)      w_dir = w_dirX;
      else if (w_y != C_Y) w_dir = w_dirY;
    end else begin
      if (w_y != C_Y)      w_dir = w_dirY;
      else if (w_x != C_X) w_dir = w_dirX;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode; also classifies each accepted flit as forwarded or
  // discarded. DROP swallows everything without flagging.
  always_comb begin
    w_nextState = r_state;
    w_fwd       = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (!w_isStart) begin
            w_err = 1'b1;
          end else if (!w_inRange) begin
            w_err = 1'b1;
            if (w_type == FLIT_HEAD) w_nextState = DROP;
          end else begin
            w_fwd = 1'b1;
            if (w_type == FLIT_HEAD) w_nextState = ROUTE;
          end
        end
        ROUTE: begin
          if (w_isStart) begin
            w_err = 1'b1;
          end else begin
            w_fwd = 1'b1;
            if (w_type == FLIT_TAIL) w_nextState = IDLE;
          end
        end
        DROP: begin
          if (w_type == FLIT_TAIL) w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Outputs derived from registered state. DROP always accepts so a dropped
  // packet drains regardless of downstream backpressure.
  always_comb begin
    ready_o = (r_state == DROP) || !r_valid || ready_i;
    busy_o  = (r_state != IDLE);
  end

  // Output stage: a new forward overwrites the register even while the old
  // flit is being taken, so back-to-back flits stream without bubbles. The
  // direction is relatched only by a packet-starting flit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= DIR_RESOURCE;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_fwd) begin
        r_valid <= 1'b1;
        r_data  <= data_i;
        if (w_isStart) r_sel <= w_dir;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign out_sel_o = r_sel;
  assign err_o     = r_err;

`ifdef XY_ROUTE_STATS_EN
  logic [15:0] r_pktCnt;
  logic [15:0] r_dropCnt;

  // Tail and single share the high type bit, so that marks a packet end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pktCnt  <= '0;
      r_dropCnt <= '0;
    end else begin
      if (w_fwd && w_type[1]) r_pktCnt  <= r_pktCnt + 16'd1;
      if (w_err)              r_dropCnt <= r_dropCnt + 16'd1;
    end
  end

  assign pkt_cnt_o  = r_pktCnt;
  assign drop_cnt_o = r_dropCnt;
`endif

endmodule

// File: tb/tb_xy_route_unit.sv
// ---------------------------------------------------------------------------
// tb_xy_route_unit
//
// Drives an XY-order and a YX-order instance (router at 1,1 in a 4x4 mesh)
// with identical stimulus and compares both against a packet-level model.
// ---------------------------------------------------------------------------
module tb_xy_route_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       readyDown;
  logic [9:0] dataIn;

  logic       ready0, valid0, busy0, err0;
  logic [9:0] data0;
  logic [2:0] sel0;
  logic       readyYx, validYx, busyYx, errYx;
  logic [9:0] dataYx;
  logic [2:0] selYx;

  int checks = 0;
  int errors = 0;

  // Packet-level reference model state
  bit         modelKnown = 1'b0;
  bit         mInPacket;
  bit         mDropping;
  bit         mValid;
  bit         mErr;
  logic [9:0] mData;
  int         mSel;
  int         mSelYx;

  logic [9:0] delivered[$];

  typedef struct {
    bit         v;
    logic [9:0] d;
    bit         rd;
    bit         eReady;
    bit         eValid;
    logic [9:0] eData;
    int         eSel;
    int         eSelYx;
    bit         eBusy;
    bit         eErr;
  } vec_t;

  vec_t tbl[$];

  xy_route_unit #(
    .X_CORD(1), .Y_CORD(1), .PACKET_ADDR_X_W(4), .PACKET_ADDR_Y_W(4),
    .OUTPUT_N_W(3), .FLIT_DATA_W(8), .MESH_X(4), .MESH_Y(4), .ROUTE_MODE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .valid_i(valid),
    .ready_o(ready0), .data_o(data0), .valid_o(valid0), .ready_i(readyDown),
    .out_sel_o(sel0), .busy_o(busy0), .err_o(err0)
  );

  xy_route_unit #(
    .X_CORD(1), .Y_CORD(1), .PACKET_ADDR_X_W(4), .PACKET_ADDR_Y_W(4),
    .OUTPUT_N_W(3), .FLIT_DATA_W(8), .MESH_X(4), .MESH_Y(4), .ROUTE_MODE(1)
  ) dutYx (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .valid_i(valid),
    .ready_o(readyYx), .data_o(dataYx), .valid_o(validYx), .ready_i(readyDown),
    .out_sel_o(selYx), .busy_o(busyYx), .err_o(errYx)
  );

  always #5 clk = ~clk;

  // Records every flit the downstream side actually takes.
  always @(negedge clk) begin
    if (!rst && valid0 && readyDown) delivered.push_back(data0);
  end

  function automatic int routeDir(int x, int y, bit yFirst);
    int dx = x - 1;
    int dy = y - 1;
    int hx = (dx > 0) ? 2 : ((dx < 0) ? 1 : 0);
    int hy = (dy > 0) ? 3 : ((dy < 0) ? 4 : 0);
    if (!yFirst) return (dx != 0) ? hx : hy;
    return (dy != 0) ? hy : hx;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit modelReady(input bit rd);
    return mDropping || !mValid || rd;
  endfunction

  // Advances the model by one clock using the packet rules directly.
  task automatic modelStep(input bit r, input bit v, input logic [9:0] d, input bit rd);
    bit acc;
    bit fwd;
    bit err;
    int kind;
    int x;
    int y;
    if (r) begin
      modelKnown = 1'b1;
      mInPacket = 0; mDropping = 0; mValid = 0; mErr = 0;
      mData = '0; mSel = 0; mSelYx = 0;
      return;
    end
    acc  = v && modelReady(rd);
    kind = int'(d[9:8]);
    x    = int'(d[3:0]);
    y    = int'(d[7:4]);
    fwd  = 0;
    err  = 0;
    if (acc) begin
      if (mDropping) begin
        if (kind == 2) mDropping = 0;
      end else if (mInPacket) begin
        if (kind == 1 || kind == 3) err = 1;
        else begin
          fwd = 1;
          if (kind == 2) mInPacket = 0;
        end
      end else begin
        if (kind == 0 || kind == 2) err = 1;
        else if (x >= 4 || y >= 4) begin
          err = 1;
          if (kind == 1) mDropping = 1;
        end else begin
          fwd    = 1;
          mSel   = routeDir(x, y, 1'b0);
          mSelYx = routeDir(x, y, 1'b1);
          if (kind == 1) mInPacket = 1;
        end
      end
    end
    if (fwd) begin
      mValid = 1;
      mData  = d;
    end else if (rd) begin
      mValid = 0;
    end
    mErr = err;
  endtask

  task automatic checkOutput();
    check("valid_o", int'(valid0), int'(mValid));
    check("data_o", int'(data0), int'(mData));
    check("out_sel_o", int'(sel0), mSel);
    check("busy_o", int'(busy0), int'(mInPacket || mDropping));
    check("err_o", int'(err0), int'(mErr));
    check("out_sel_o_yx", int'(selYx), mSelYx);
    check("valid_o_yx", int'(validYx), int'(mValid));
  endtask

  // Drives one cycle of inputs, checks ready_o before the edge and all
  // registered outputs just after it.
  task automatic applyStimulus(input bit r, input bit v, input logic [9:0] d, input bit rd);
    rst = r; valid = v; dataIn = d; readyDown = rd;
    #1;
    if (modelKnown) begin
      check("ready_o", int'(ready0), int'(modelReady(rd)));
      check("ready_o_yx", int'(readyYx), int'(modelReady(rd)));
    end
    modelStep(r, v, d, rd);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runVector(input vec_t vv);
    rst = 1'b0; valid = vv.v; dataIn = vv.d; readyDown = vv.rd;
    #1;
    check("tbl_ready", int'(ready0), int'(vv.eReady));
    applyStimulus(1'b0, vv.v, vv.d, vv.rd);
    check("tbl_valid", int'(valid0), int'(vv.eValid));
    check("tbl_data", int'(data0), int'(vv.eData));
    check("tbl_sel", int'(sel0), vv.eSel);
    check("tbl_sel_yx", int'(selYx), vv.eSelYx);
    check("tbl_busy", int'(busy0), int'(vv.eBusy));
    check("tbl_err", int'(err0), int'(vv.eErr));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; dataIn = '0; readyDown = 1'b1;

    // Flit = {type, y, x}: head x3y0, body, tail, idle, singles, dropped
    // packet x5y0, then a stray body in IDLE.
    tbl.push_back('{1'b1, 10'h103, 1'b1, 1'b1, 1'b1, 10'h103, 2, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h0AA, 1'b1, 1'b1, 1'b1, 10'h0AA, 2, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h255, 1'b1, 1'b1, 1'b1, 10'h255, 2, 4, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h255, 2, 4, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 10'h303, 1'b1, 1'b1, 1'b1, 10'h303, 2, 4, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 10'h311, 1'b1, 1'b1, 1'b1, 10'h311, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 10'h105, 1'b1, 1'b1, 1'b0, 10'h311, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 10'h0AA, 1'b1, 1'b1, 1'b0, 10'h311, 0, 0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h0BB, 1'b0, 1'b1, 1'b0, 10'h311, 0, 0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h255, 1'b1, 1'b1, 1'b0, 10'h311, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 10'h0AA, 1'b1, 1'b1, 1'b0, 10'h311, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h311, 0, 0, 1'b0, 1'b0});

    applyStimulus(1'b1, 1'b0, 10'h000, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'h000, 1'b1);

    foreach (tbl[i]) runVector(tbl[i]);

    // Backpressure mid-packet: nothing lost, duplicated or reordered.
    delivered.delete();
    applyStimulus(1'b0, 1'b1, 10'h103, 1'b1);
    applyStimulus(1'b0, 1'b1, 10'h0AA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 10'h0BB, 1'b0);
      check("stall_ready", int'(ready0), 0);
      check("stall_data", int'(data0), 10'h0AA);
      check("stall_sel", int'(sel0), 2);
    end
    applyStimulus(1'b0, 1'b1, 10'h0BB, 1'b1);
    applyStimulus(1'b0, 1'b1, 10'h255, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    check("stall_count", delivered.size(), 4);
    if (delivered.size() == 4) begin
      check("stall_order0", int'(delivered[0]), 10'h103);
      check("stall_order1", int'(delivered[1]), 10'h0AA);
      check("stall_order2", int'(delivered[2]), 10'h0BB);
      check("stall_order3", int'(delivered[3]), 10'h255);
    end

    // Head during ROUTE is flagged and leaves the locked direction alone.
    applyStimulus(1'b0, 1'b1, 10'h103, 1'b1);
    applyStimulus(1'b0, 1'b1, 10'h110, 1'b1);
    check("route_head_err", int'(err0), 1);
    check("route_head_sel", int'(sel0), 2);
    applyStimulus(1'b0, 1'b1, 10'h255, 1'b1);

    // Reset mid-packet, then a fresh single x0y1 goes WEST in both orders.
    applyStimulus(1'b0, 1'b1, 10'h103, 1'b1);
    applyStimulus(1'b0, 1'b1, 10'h0AA, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h000, 1'b1);
    check("rst_valid", int'(valid0), 0);
    check("rst_busy", int'(busy0), 0);
    applyStimulus(1'b0, 1'b1, 10'h310, 1'b1);
    check("rst_single_sel", int'(sel0), 1);
    check("rst_single_sel_yx", int'(selYx), 1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [9:0] d;
      d[9:8] = 2'($urandom_range(0, 3));
      d[7:4] = 4'($urandom_range(0, 5));
      d[3:0] = 4'($urandom_range(0, 5));
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, d,
                    $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
